// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM states and default sizes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StComplete = 2'd2
  } state_e;

  localparam int unsigned DefNumReq     = 2;
  localparam int unsigned DefMaddrWidth = 16;
  localparam int unsigned DefMdataWidth = 16;
  localparam int unsigned DefTimeout    = 255;

  // Width of a requester index; at least one bit so a single requester still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after last_owner wins.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_owner,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 valid
);

  logic [IDX_WIDTH-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest one after last_owner wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = int'(NUM_REQ); i > 0; i--) begin
      cand = IDX_WIDTH'((int'(last_owner) + i) % int'(NUM_REQ));
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters with round-robin arbitration,
// a per-transaction ready timeout and one-cycle done/error completion pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned MADDR_WIDTH = DefMaddrWidth,
  parameter int unsigned MDATA_WIDTH = DefMdataWidth,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             error,
  output logic [MDATA_WIDTH-1:0]         rdata,
  output logic                           mem_read_enable,
  output logic                           mem_write_enable,
  output logic [MADDR_WIDTH-1:0]         mem_addr,
  output logic [MDATA_WIDTH-1:0]         mem_write_data,
  input  logic [MDATA_WIDTH-1:0]         mem_read_data,
  input  logic                           mem_read_ready,
  input  logic                           mem_write_ready,
  output logic                           busy
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  state_e          state;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] last_owner;
  logic            is_write;
  logic [CntW-1:0] wait_cnt;
  logic [CntW-1:0] cnt_inc;
  logic            ready_hit;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  logic [MADDR_WIDTH-1:0] addr_slot  [NUM_REQ];
  logic [MDATA_WIDTH-1:0] wdata_slot [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_slot[k]  = req_addr[k*MADDR_WIDTH +: MADDR_WIDTH];
    assign wdata_slot[k] = req_wdata[k*MDATA_WIDTH +: MDATA_WIDTH];
  end

  mem_port_arbiter_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IdxW)
  ) rr_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  // Only the ready matching the latched direction can finish a transaction.
  always_comb begin
    ready_hit = is_write ? mem_write_ready : mem_read_ready;
    cnt_inc   = wait_cnt + CntW'(1);
  end

  // Transaction FSM; every output is registered and follows the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= StIdle;
      owner            <= '0;
      last_owner       <= IdxW'(NUM_REQ - 1);
      is_write         <= 1'b0;
      wait_cnt         <= '0;
      gnt              <= '0;
      done             <= '0;
      error            <= '0;
      rdata            <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
    end else begin
      done  <= '0;
      error <= '0;
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            owner            <= pick_idx;
            is_write         <= req_write[pick_idx];
            mem_addr         <= addr_slot[pick_idx];
            mem_write_data   <= wdata_slot[pick_idx];
            mem_write_enable <= req_write[pick_idx];
            mem_read_enable  <= ~req_write[pick_idx];
            gnt              <= NUM_REQ'(1) << pick_idx;
            wait_cnt         <= '0;
            busy             <= 1'b1;
            state            <= StIssue;
          end
        end
        StIssue: begin
          if (ready_hit) begin
            if (!is_write) begin
              rdata <= mem_read_data;
            end
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            done             <= gnt;
            state            <= StComplete;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == TimeoutVal) begin
              mem_read_enable  <= 1'b0;
              mem_write_enable <= 1'b0;
              mem_addr         <= '0;
              mem_write_data   <= '0;
              error            <= gnt;
              state            <= StComplete;
            end
          end
        end
        StComplete: begin
          gnt        <= '0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_write;
  logic [AW-1:0] a_arr [NR];
  logic [DW-1:0] d_arr [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] gnt, done, error;
  logic [DW-1:0] rdata;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          mem_read_ready, mem_write_ready;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who was served last and what rdata should hold.
  int            m_last = NR - 1;
  logic [DW-1:0] m_rdata = '0;

  assign req_addr  = {a_arr[1], a_arr[0]};
  assign req_wdata = {d_arr[1], d_arr[0]};

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .NUM_REQ     (NR),
    .MADDR_WIDTH (AW),
    .MDATA_WIDTH (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .gnt              (gnt),
    .done             (done),
    .error            (error),
    .rdata            (rdata),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_read_ready   (mem_read_ready),
    .mem_write_ready  (mem_write_ready),
    .busy             (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Round-robin rule: first valid requester after the last one served.
  function automatic int model_pick(input logic [NR-1:0] v, input int last);
    for (int i = 1; i <= NR; i++) begin
      int k = (last + i) % NR;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Runs one transaction starting in an IDLE cycle (#1 after a posedge) with req_* driven.
  // delay: ISSUE cycles before the matching ready (>= TO means never); opp: 0 low,
  // 1 random, 2 held high on the opposite-direction ready.
  task automatic serve(input int delay, input int opp, input bit drop, input bit keep,
                       input logic [DW-1:0] data, output logic [NR-1:0] first_gnt);
    int            w;
    int            en_cnt;
    bit            ew, hit, timed_out, opp_val;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [NR-1:0] eg;
    first_gnt = '0;
    w = model_pick(req_valid, m_last);
    if (w < 0) return;
    ew        = req_write[w[0]];
    ea        = a_arr[w[0]];
    ed        = d_arr[w[0]];
    eg        = NR'(1) << w;
    timed_out = (delay >= TO);
    @(posedge clock); #1;
    // Withdrawing the request and scribbling its payload must not disturb the transaction.
    if (drop) begin
      req_valid[w[0]] = 1'b0;
      a_arr[w[0]]     = 16'($urandom);
      d_arr[w[0]]     = 16'($urandom);
    end
    en_cnt = 0;
    for (int n = 0; n < TO; n++) begin
      @(negedge clock);
      if (n == 0) first_gnt = gnt;
      check_eq("issue_gnt", 32'(gnt), 32'(eg));
      check_eq("issue_rd_en", 32'(mem_read_enable), 32'(!ew));
      check_eq("issue_wr_en", 32'(mem_write_enable), 32'(ew));
      check_eq("issue_addr", 32'(mem_addr), 32'(ea));
      check_eq("issue_wdata", 32'(mem_write_data), 32'(ed));
      check_eq("issue_done_err", 32'({done, error}), 32'(0));
      check_eq("issue_busy", 32'(busy), 32'(1));
      if (mem_read_enable || mem_write_enable) en_cnt++;
      hit     = (n == delay);
      opp_val = (opp == 2) ? 1'b1 : (opp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_write_ready = ew ? hit : opp_val;
      mem_read_ready  = ew ? opp_val : hit;
      mem_read_data   = hit ? data : 16'($urandom);
      @(posedge clock); #1;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 16'($urandom);
      if (hit) break;
    end
    @(negedge clock);
    if (!ew && !timed_out) m_rdata = data;
    check_eq("en_cycles", 32'(en_cnt), 32'(timed_out ? TO : delay + 1));
    check_eq("cpl_done", 32'(done), 32'(timed_out ? '0 : eg));
    check_eq("cpl_error", 32'(error), 32'(timed_out ? eg : '0));
    check_eq("cpl_gnt", 32'(gnt), 32'(eg));
    check_eq("cpl_enables", 32'({mem_read_enable, mem_write_enable}), 32'(0));
    check_eq("cpl_addr_data", {mem_addr, mem_write_data}, 32'(0));
    check_eq("cpl_rdata", 32'(rdata), 32'(m_rdata));
    check_eq("cpl_busy", 32'(busy), 32'(1));
    m_last = w;
    @(posedge clock); #1;
    check_eq("idle_gnt", 32'(gnt), 32'(0));
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_pulses", 32'({done, error}), 32'(0));
    if (!keep) req_valid[w[0]] = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] fg;
    reset           = 1'b1;
    req_valid       = '0;
    req_write       = '0;
    a_arr[0]        = '0;
    a_arr[1]        = '0;
    d_arr[0]        = '0;
    d_arr[1]        = '0;
    mem_read_data   = '0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'(0));
    check_eq("rst_pulses", 32'({done, error}), 32'(0));
    check_eq("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'(0));
    check_eq("rst_addr_data", {mem_addr, mem_write_data}, 32'(0));
    check_eq("rst_rdata", 32'(rdata), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Collision: both writes arrive together, requester 0 goes first.
    req_valid = 2'b11;
    req_write = 2'b11;
    a_arr[0] = 16'h0020; d_arr[0] = 16'h1111;
    a_arr[1] = 16'h0030; d_arr[1] = 16'h2222;
    serve(0, 0, 1'b0, 1'b0, 16'h0, fg);
    check_eq("collision_first", 32'(fg), 32'(2'b01));
    serve(0, 0, 1'b0, 1'b0, 16'h0, fg);
    check_eq("collision_second", 32'(fg), 32'(2'b10));

    // Fairness: both held for six transactions alternate 0,1,0,1,0,1.
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve(0, 0, 1'b0, 1'b1, 16'h0, fg);
      check_eq("fair_order", 32'(fg), 32'(2'b01 << (i % 2)));
    end
    req_valid = 2'b00;
    @(posedge clock); #1;

    // Single read with two wait cycles.
    req_valid = 2'b01; req_write = 2'b00; a_arr[0] = 16'h0010;
    serve(2, 0, 1'b0, 1'b0, 16'hBEEF, fg);
    check_eq("read_rdata", 32'(rdata), 32'h0000_BEEF);

    // Timeout: ready never arrives.
    req_valid = 2'b10; req_write = 2'b00; a_arr[1] = 16'h0077;
    serve(100, 0, 1'b0, 1'b0, 16'h0, fg);
    check_eq("timeout_rdata_kept", 32'(rdata), 32'h0000_BEEF);

    // Wrong-direction ready held high while a write waits.
    req_valid = 2'b01; req_write = 2'b01; a_arr[0] = 16'h0055; d_arr[0] = 16'hA5A5;
    serve(3, 2, 1'b0, 1'b0, 16'h0, fg);

    // Reset in the second ISSUE cycle abandons the transaction.
    req_valid = 2'b01; req_write = 2'b00; a_arr[0] = 16'h0040;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("rst_mid_pre_gnt", 32'(gnt), 32'(2'b01));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset     = 1'b0;
    req_valid = 2'b00;
    @(negedge clock);
    check_eq("rst_mid_gnt", 32'(gnt), 32'(0));
    check_eq("rst_mid_enables", 32'({mem_read_enable, mem_write_enable}), 32'(0));
    check_eq("rst_mid_pulses", 32'({done, error}), 32'(0));
    check_eq("rst_mid_busy", 32'(busy), 32'(0));
    m_last  = NR - 1;
    m_rdata = '0;
    @(posedge clock); #1;
    check_eq("rst_mid_no_done", 32'({done, error}), 32'(0));
    req_valid = 2'b10; req_write = 2'b00; a_arr[1] = 16'h0099;
    serve(1, 0, 1'b0, 1'b0, 16'h1234, fg);
    check_eq("rst_mid_next_gnt", 32'(fg), 32'(2'b10));

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k[0]] && $urandom_range(0, 3) != 0) begin
          req_valid[k[0]] = 1'b1;
          req_write[k[0]] = 1'($urandom_range(0, 1));
          a_arr[k[0]]     = 16'($urandom);
          d_arr[k[0]]     = 16'($urandom);
        end
      end
      if (req_valid == '0) begin
        @(posedge clock); #1;
        check_eq("idle_stay", 32'({gnt, busy}), 32'(0));
      end else begin
        serve(int'($urandom_range(0, 5)), 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, 16'($urandom), fg);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2; number of requesters sharing the memory port.
REQ-002 Parameter MADDR_WIDTH, default 16; memory address width.
REQ-003 Parameter MDATA_WIDTH, default 16; memory data width.
REQ-004 Parameter TIMEOUT, default 255; maximum cycles spent waiting for memory ready.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request, held until the matching done or error.
REQ-008 req_write  input  NUM_REQ  per-requester direction: 1 = write, 0 = read.
REQ-009 req_addr  input  NUM_REQ*MADDR_WIDTH  packed addresses; requester k uses slice k.
REQ-010 req_wdata  input  NUM_REQ*MDATA_WIDTH  packed write data; requester k uses slice k.
REQ-011 gnt  output  NUM_REQ  one-hot owner of the port, zero when idle.
REQ-012 done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 error  output  NUM_REQ  one-cycle timeout pulse to the owner.
REQ-014 rdata  output  MDATA_WIDTH  captured read data; valid in the done cycle and held until the next capture.
REQ-015 mem_read_enable, mem_write_enable  output  1 each  memory strobes.
REQ-016 mem_addr  output  MADDR_WIDTH; mem_write_data  output  MDATA_WIDTH.
REQ-017 mem_read_data  input  MDATA_WIDTH; mem_read_ready, mem_write_ready  input  1 each.
REQ-018 busy  output  1  high in every state other than IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, COMPLETE.
REQ-020 IDLE behaviour:
- If any req_valid is high, select the winner round-robin, searching from (last_owner+1) mod NUM_REQ.
- Latch the winner's index, write bit, address and data.
- Go to ISSUE.
REQ-021 ISSUE behaviour:
- gnt[owner] = 1.
- Exactly one of mem_read_enable/mem_write_enable is high, per the latched direction.
- mem_addr and mem_write_data are driven from the latches; they stay constant for the whole transaction.
REQ-022 In ISSUE, the ready matching the direction is sampled each cycle. On the edge where it is high:
- on a read, capture mem_read_data into rdata;
- drop the enables;
- go to COMPLETE.
REQ-023 The opposite-direction ready is ignored throughout.
REQ-024 COMPLETE behaviour:
- done[owner] pulses for one cycle with gnt still high.
- last_owner is updated.
- Return to IDLE; gnt clears.
REQ-025 Best-case latency is 3 cycles: request sampled at edge 0, done high in cycle 2, new arbitration at edge 3.
REQ-026 Timeout:
- An 8-bit counter (clog2(TIMEOUT+1) bits) clears on entering ISSUE and increments each ISSUE cycle without ready.
- When the counter reaches TIMEOUT, drop the enables and go to COMPLETE.
- That COMPLETE cycle pulses error instead of done; rdata is unchanged.
REQ-027 Deasserting req_valid mid-transaction does not abort it; completion is still signalled.
REQ-028 Simultaneous requests: only one is granted; the others wait in order. No requester is starved for more than NUM_REQ-1 transactions.
REQ-029 A requester whose req_valid is still high in the IDLE cycle after its done competes again as a new request.
REQ-030 mem_addr and mem_write_data are 0 whenever no enable is high.

Reset
REQ-031 Reset values:
- State IDLE.
- gnt, done, error, enables, mem_addr, mem_write_data, rdata, busy all 0.
- last_owner = NUM_REQ-1, so requester 0 has first priority.
- Counter 0.
REQ-032 Reset asserted mid-transaction drops all enables at that edge; the outstanding transaction is abandoned without done or error.

Structure
REQ-033 The shared constants package holds the state enum (IDLE/ISSUE/COMPLETE) and the default widths and TIMEOUT.
REQ-034 One sub-module, rr_pick, is used: a combinational round-robin selector taking the request vector and last_owner and returning the winner index and a valid flag.

Verification
REQ-035 Single read: req_valid=01, req_write=0, addr0=0x0010, ready after 2 wait cycles with data 0xBEEF -> mem_read_enable high 3 cycles at 0x0010; done=01 once; rdata=0xBEEF.
REQ-036 Collision: req_valid=11 sampled together, both writes (0x0020/0x1111 and 0x0030/0x2222), ready immediate -> req0 served first, then req1; gnt never 11; done pulses 01 then 10.
REQ-037 Fairness: both requesters held high for 6 transactions -> grant order 0,1,0,1,0,1.
REQ-038 Timeout: TIMEOUT=4, no ready ever -> enable high exactly 4 cycles; error pulses for the owner; done stays 0; busy returns to 0.
REQ-039 Reset mid-wait: assert reset in the 2nd ISSUE cycle -> enables and gnt are 0 the next cycle; no done; a following request to requester 1 is granted normally.
REQ-040 Wrong-direction ready: a write is pending and mem_read_ready is pulsed -> no completion until mem_write_ready arrives.
